// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage.
//   alu_flags_t         : status flags carried with every result beat
//   ALU_DEFAULT_OP_MASK : default implemented-op mask (op 6 unimplemented)
//   skid_state_t        : occupancy state of the two-entry skid buffer
// The result+flags beat struct depends on the datapath width, so each
// module that needs it builds it locally from alu_flags_t.
package alu_pkg;

    localparam logic [7:0] ALU_DEFAULT_OP_MASK = 8'b1011_1111;

    typedef struct packed {
        logic neg;
        logic zero;
        logic illegal;
    } alu_flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Generic two-entry valid/ready skid buffer.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous flush, empties the buffer next cycle
//   i_valid/o_ready   : upstream handshake, i_data is the beat
//   o_valid/i_ready   : downstream handshake, o_data is the beat
//   o_state           : current occupancy state (debug)
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. Valid never depends on ready; o_ready and
// o_valid are plain registers, so there is no combinational path from
// i_ready to o_ready. Beats leave in arrival order; the skid entry always
// drains into the output register before any newer beat.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int W = 35
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [W-1:0] i_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [W-1:0] o_data,
    output skid_state_t o_state
);

    skid_state_t r_state;
    skid_state_t w_next_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [W-1:0] r_or;
    logic [W-1:0] r_sr;

    logic w_accept;
    logic w_deliver;
    logic w_load_or_in;
    logic w_load_or_sr;
    logic w_load_sr;

    assign w_accept  = i_valid && r_in_ready && !flush;
    assign w_deliver = r_out_valid && i_ready;

    always_comb begin
        w_next_state = r_state;
        w_load_or_in = 1'b0;
        w_load_or_sr = 1'b0;
        w_load_sr    = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next_state = ONE;
                    w_load_or_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_deliver) begin
                    w_load_or_in = 1'b1;
                end else if (w_accept) begin
                    w_next_state = TWO;
                    w_load_sr    = 1'b1;
                end else if (w_deliver) begin
                    w_next_state = EMPTY;
                end
            end
            TWO: begin
                // o_ready is low here, so only a delivery can happen.
                if (w_deliver) begin
                    w_next_state = ONE;
                    w_load_or_sr = 1'b1;
                end
            end
            default: w_next_state = EMPTY;
        endcase
        // Flush wins over everything; any held beats are dropped.
        if (flush) begin
            w_next_state = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_or        <= '0;
            r_sr        <= '0;
        end else begin
            r_state     <= w_next_state;
            // Handshake outputs are registered copies of the next-state decode.
            r_in_ready  <= (w_next_state != TWO);
            r_out_valid <= (w_next_state != EMPTY);
            if (w_load_or_in) begin
                r_or <= i_data;
            end else if (w_load_or_sr) begin
                r_or <= r_sr;
            end
            if (w_load_sr) begin
                r_sr <= i_data;
            end
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_or;
    assign o_state = r_state;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result selector with flag generation and a skid-buffered
// valid/ready output.
//   clk, rst_n       : clock, asynchronous active-low reset
//   flush            : synchronous pipeline flush (does not clear the counter)
//   in_valid/in_ready: input handshake; results (NUM_OPS*N) and sel per beat
//   out_valid/out_ready: output handshake
//   out_result       : selected result (0 for an illegal select)
//   out_neg/out_zero/out_illegal : flags registered with the result
//   illegal_count    : saturating count of accepted illegal beats
//   dbg_state        : skid buffer occupancy state (debug)
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int                   N       = 32,
    parameter int                   NUM_OPS = 8,
    // Derived from NUM_OPS; leave at its default.
    parameter int                   SEL_W   = $clog2(NUM_OPS),
    parameter logic [NUM_OPS-1:0]   OP_MASK = NUM_OPS'(ALU_DEFAULT_OP_MASK),
    parameter int                   CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_OPS*N-1:0] results,
    input  logic [SEL_W-1:0]     sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_result,
    output logic                 out_neg,
    output logic                 out_zero,
    output logic                 out_illegal,
    output logic [CNT_W-1:0]     illegal_count,
    output skid_state_t          dbg_state
);

    typedef struct packed {
        logic [N-1:0] result;
        alu_flags_t   flags;
    } alu_beat_t;

    logic [N-1:0] w_sel_result;
    logic         w_sel_legal;
    logic [N-1:0] w_result;
    alu_beat_t    w_beat;
    alu_beat_t    w_out_beat;
    logic         w_accept;
    logic [CNT_W-1:0] r_illegal_count;

    // A select that matches no op index (sel >= NUM_OPS) leaves w_sel_legal
    // low, as does an op whose mask bit is clear.
    always_comb begin
        w_sel_result = '0;
        w_sel_legal  = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (sel == SEL_W'(i)) begin
                w_sel_result = results[i*N +: N];
                w_sel_legal  = OP_MASK[i];
            end
        end
    end

    // Illegal selects yield zero, which makes zero=1 and neg=0 fall out.
    assign w_result             = w_sel_legal ? w_sel_result : '0;
    assign w_beat.result        = w_result;
    assign w_beat.flags.neg     = w_result[N-1];
    assign w_beat.flags.zero    = (w_result == '0);
    assign w_beat.flags.illegal = !w_sel_legal;

    alu_skid_buf #(
        .W($bits(alu_beat_t))
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_beat),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_beat),
        .o_state (dbg_state)
    );

    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_count <= '0;
        end else if (w_accept && w_beat.flags.illegal && (r_illegal_count != '1)) begin
            r_illegal_count <= r_illegal_count + CNT_W'(1);
        end
    end

    assign out_result    = w_out_beat.result;
    assign out_neg       = w_out_beat.flags.neg;
    assign out_zero      = w_out_beat.flags.zero;
    assign out_illegal   = w_out_beat.flags.illegal;
    assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int N = 32;
  localparam int NOPS = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [NOPS*N-1:0] results = '0;
  logic [2:0]      sel = '0;
  logic            out_ready = 1'b0;

  // main DUT (CNT_W = 16)
  logic            in_ready;
  logic            out_valid;
  logic [N-1:0]    out_result;
  logic            out_neg, out_zero, out_illegal;
  logic [15:0]     illegal_count;
  skid_state_t     dbg_state;

  // saturation DUT (CNT_W = 2)
  logic            s_in_ready;
  logic            s_out_valid;
  logic [N-1:0]    s_out_result;
  logic            s_out_neg, s_out_zero, s_out_illegal;
  logic [1:0]      s_illegal_count;
  skid_state_t     s_dbg_state;

  alu_result_stage #(.N(N), .NUM_OPS(NOPS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .results(results), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_neg(out_neg), .out_zero(out_zero),
    .out_illegal(out_illegal), .illegal_count(illegal_count), .dbg_state(dbg_state)
  );

  alu_result_stage #(.N(N), .NUM_OPS(NOPS), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .results(results), .sel(sel), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_result(s_out_result), .out_neg(s_out_neg), .out_zero(s_out_zero),
    .out_illegal(s_out_illegal), .illegal_count(s_illegal_count), .dbg_state(s_dbg_state)
  );

  // reference model: FIFO of at most two beats {result, neg, zero, illegal}
  logic [N+2:0] exp_q[$];
  logic [7:0]   op_mask_ref = 8'b1011_1111;
  int           m_cnt = 0;
  int           m_cnt_sat = 0;
  logic         last_accepted = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N+2:0] ref_beat(input logic [NOPS*N-1:0] r, input logic [2:0] s);
    logic [N-1:0] v;
    logic legal;
    legal = op_mask_ref[s];
    v = legal ? r[s*N +: N] : '0;
    return {v, v[N-1], (v == 0), !legal};
  endfunction

  // advance the model by one rising edge, using the inputs the DUT saw
  task automatic model_edge();
    bit deliver, accept;
    logic [N+2:0] b;
    deliver = (exp_q.size() > 0) && out_ready;
    accept  = in_valid && (exp_q.size() < 2) && !flush;
    b = ref_beat(results, sel);
    if (deliver) void'(exp_q.pop_front());
    if (accept) begin
      exp_q.push_back(b);
      if (b[0]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
    end
    if (flush) exp_q.delete();
    last_accepted = accept;
  endtask

  task automatic check_outputs();
    logic [N+2:0] f;
    check("in_ready", in_ready, exp_q.size() < 2);
    check("out_valid", out_valid, exp_q.size() > 0);
    check("sat_in_ready", s_in_ready, exp_q.size() < 2);
    check("sat_out_valid", s_out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      check("out_result", out_result, f[N+2:3]);
      check("out_neg", out_neg, f[2]);
      check("out_zero", out_zero, f[1]);
      check("out_illegal", out_illegal, f[0]);
      check("sat_out_result", s_out_result, f[N+2:3]);
    end
    check("illegal_count", illegal_count, m_cnt);
    check("sat_illegal_count", s_illegal_count, m_cnt_sat);
  endtask

  // driver: apply inputs after a falling edge, step one cycle, check
  task automatic cycle(input logic v, input logic [2:0] s, input logic [NOPS*N-1:0] r,
                       input logic ordy, input logic fl);
    in_valid = v; sel = s; results = r; out_ready = ordy; flush = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 3'd0, '0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 0; sel = 0; results = '0;
    rst_n = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_cnt_sat = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_flags", {out_neg, out_zero, out_illegal}, 0);
    check("rst_count", illegal_count, 0);
    rst_n = 1'b1;
  endtask

  function automatic logic [NOPS*N-1:0] rand_results();
    logic [NOPS*N-1:0] r;
    for (int i = 0; i < NOPS; i++) begin
      case ($urandom_range(0, 3))
        0: r[i*N +: N] = '0;
        1: r[i*N +: N] = 32'h8000_0000;
        default: r[i*N +: N] = $urandom;
      endcase
    end
    return r;
  endfunction

  logic [NOPS*N-1:0] tbl;
  int sels[7] = '{0, 1, 2, 3, 4, 5, 7};

  initial begin
    do_reset();

    // legal ops back to back, results[i] = i+1
    for (int i = 0; i < NOPS; i++) tbl[i*N +: N] = i + 1;
    for (int k = 0; k < 7; k++) cycle(1'b1, 3'(sels[k]), tbl, 1'b1, 1'b0);
    idle(1'b1);

    // illegal op 6
    tbl[6*N +: N] = 32'hDEAD_BEEF;
    cycle(1'b1, 3'd6, tbl, 1'b1, 1'b0);
    check("illegal_result", out_result, 0);
    check("illegal_flag", {out_zero, out_illegal}, 2'b11);
    check("illegal_count_1", illegal_count, 1);
    idle(1'b1);

    // flag patterns
    tbl[0 +: N] = 32'h8000_0000;
    tbl[N +: N] = 32'h0;
    cycle(1'b1, 3'd0, tbl, 1'b1, 1'b0);
    check("neg_flag", {out_neg, out_zero}, 2'b10);
    cycle(1'b1, 3'd1, tbl, 1'b1, 1'b0);
    check("zero_legal", {out_zero, out_illegal}, 2'b10);
    idle(1'b1);

    // stall / skid: A, B, C with out_ready low
    for (int i = 0; i < NOPS; i++) tbl[i*N +: N] = 32'hA0 + i;
    cycle(1'b1, 3'd2, tbl, 1'b0, 1'b0);  // A
    cycle(1'b1, 3'd3, tbl, 1'b0, 1'b0);  // B
    cycle(1'b1, 3'd4, tbl, 1'b0, 1'b0);  // C held off
    check("stall_in_ready", in_ready, 0);
    check("stall_A_stable", out_result, 32'hA2);
    cycle(1'b1, 3'd4, tbl, 1'b0, 1'b0);
    check("stall_A_still", out_result, 32'hA2);
    begin
      int budget = 8;
      last_accepted = 1'b0;
      while (!last_accepted && budget > 0) begin
        cycle(1'b1, 3'd4, tbl, 1'b1, 1'b0);
        budget--;
      end
      check("stall_C_accepted", last_accepted, 1);
    end
    repeat (3) idle(1'b1);

    // saturation from a clean counter
    do_reset();
    repeat (5) cycle(1'b1, 3'd6, tbl, 1'b1, 1'b0);
    check("sat_cnt_3", s_illegal_count, 2'd3);
    check("cnt16_5", illegal_count, 16'd5);
    cycle(1'b0, 3'd0, tbl, 1'b1, 1'b1);  // flush
    check("sat_after_flush", s_illegal_count, 2'd3);
    idle(1'b1);

    // flush while holding two beats, illegal beat offered in flush cycle
    cycle(1'b1, 3'd0, tbl, 1'b0, 1'b0);
    cycle(1'b1, 3'd1, tbl, 1'b0, 1'b0);
    check("two_held", in_ready, 0);
    cycle(1'b1, 3'd6, tbl, 1'b0, 1'b1);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_not_counted", illegal_count, 16'd5);
    repeat (2) idle(1'b1);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rand_results(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    // asynchronous reset between edges with beats in flight
    cycle(1'b1, 3'd6, tbl, 1'b0, 1'b0);
    cycle(1'b1, 3'd5, tbl, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 1);
    check("async_out_result", out_result, 0);
    check("async_flags", {out_neg, out_zero, out_illegal}, 0);
    check("async_count", illegal_count, 0);
    exp_q.delete();
    m_cnt = 0;
    m_cnt_sat = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) idle(1'b1);
    cycle(1'b1, 3'd7, tbl, 1'b1, 1'b0);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
